// File: rtl/ovl_pkg.sv
// Shared constants for the OVL-style checkers: fire bit positions, severity codes, counter width.
// Also provides the saturating increment used by the checker event counters.
package ovl_pkg;

    localparam int OVL_FIRE_2STATE = 0;
    localparam int OVL_FIRE_XCHECK = 1;
    localparam int OVL_FIRE_COVER  = 2;
    localparam int OVL_FIRE_W      = 3;

    localparam int OVL_SEV_FATAL   = 0;
    localparam int OVL_SEV_ERROR   = 1;
    localparam int OVL_SEV_WARNING = 2;
    localparam int OVL_SEV_INFO    = 3;

    localparam int OVL_CNT_W = 16;

    typedef logic [OVL_CNT_W-1:0] ovl_cnt_t;

    function automatic ovl_cnt_t ovl_sat_inc(input ovl_cnt_t cnt, input logic inc);
        if (inc && (cnt != '1)) begin
            return cnt + ovl_cnt_t'(1);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ovl_no_overflow_chk.sv
// Purpose: flags a bounded value stepping from MAX to above MAX or to/below MIN.
// Latency: fire and counters update on the edge that samples the offending value.
// Backpressure: none; enable=0 freezes history and counters and clears fire.
module ovl_no_overflow_chk
    import ovl_pkg::*;
#(
    parameter int          WIDTH    = 1,
    parameter int unsigned MIN      = 0,
    parameter int unsigned MAX      = 1,
    parameter int          SEVERITY = OVL_SEV_ERROR,
    parameter              MSG      = "VIOLATION",
    parameter bit          COVER_EN = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [WIDTH-1:0]      test_expr,
    output logic [OVL_FIRE_W-1:0] fire,
    output ovl_cnt_t              err_count,
    output ovl_cnt_t              cov_count
);

    // A malformed range leaves the checker permanently idle rather than firing nonsense.
    localparam bit CFG_OK = (MAX > MIN) &&
                            ((WIDTH >= 32) || ({32'd0, MAX} < (64'd1 << WIDTH)));

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);

    generate
        if (!CFG_OK) begin : g_cfg_err
            $error("ovl_no_overflow_chk: illegal range, need MIN < MAX < 2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0]      prev;
    logic                  prev_vld;
    logic [OVL_FIRE_W-1:0] fire_q;
    ovl_cnt_t              err_q;
    ovl_cnt_t              cov_q;

    logic x_det;
    logic active;
    logic eval;
    logic at_max;
    logic in_range;
    logic ovf;
    logic cov_hit;
    logic x_hit;

    always_comb begin
        x_det = 1'b0;
`ifndef SYNTHESIS
        x_det = $isunknown(test_expr);
`endif
        active   = CFG_OK && enable;
        eval     = active && !x_det;
        at_max   = (test_expr == MAX_V);
        // Strictly inside (MIN, MAX) is the only legal place to go after MAX.
        in_range = (test_expr > MIN_V) && (test_expr < MAX_V);
        ovf      = eval && prev_vld && (prev == MAX_V) && !at_max && !in_range;
        cov_hit  = COVER_EN && eval && at_max;
        x_hit    = active && x_det;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fire_q   <= '0;
            prev     <= '0;
            prev_vld <= 1'b0;
            err_q    <= '0;
            cov_q    <= '0;
        end else if (active) begin
            fire_q[OVL_FIRE_2STATE] <= ovf;
            fire_q[OVL_FIRE_XCHECK] <= x_hit;
            fire_q[OVL_FIRE_COVER]  <= cov_hit;
            // An unknown sample is not trustworthy history.
            if (!x_det) begin
                prev     <= test_expr;
                prev_vld <= 1'b1;
            end
            err_q <= ovl_sat_inc(err_q, ovf);
            cov_q <= ovl_sat_inc(cov_q, cov_hit);
        end else begin
            fire_q <= '0;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (reset && ovf) begin
            $display("OVL_NO_OVERFLOW %s @%0t: %0d -> %0d", MSG, $time, prev, test_expr);
            if (SEVERITY == OVL_SEV_FATAL) begin
                $finish;
            end
        end
    end
`endif

    assign fire      = fire_q;
    assign err_count = err_q;
    assign cov_count = cov_q;

endmodule

// File: tb/tb_ovl_no_overflow_chk.sv
// Directed checks of the overflow checker: a 1-bit instance (range 0..1) and a 4-bit
// instance (range 2..9) share clock and reset and are exercised one after the other.
module tb_ovl_no_overflow_chk;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en1 = 1'b1;
    logic [0:0] te1 = '0;
    logic [2:0] fire1;
    logic [15:0] err1;
    logic [15:0] cov1;
    logic       en4 = 1'b0;
    logic [3:0] te4 = '0;
    logic [2:0] fire4;
    logic [15:0] err4;
    logic [15:0] cov4;

    int n_chk  = 0;
    int n_fail = 0;
    logic exp_x;

    always #5 clk = ~clk;

    ovl_no_overflow_chk #(
        .WIDTH(1), .MIN(0), .MAX(1), .SEVERITY(3), .MSG("W1"), .COVER_EN(1'b1)
    ) dut1 (
        .clock(clk), .reset(rst_n), .enable(en1), .test_expr(te1),
        .fire(fire1), .err_count(err1), .cov_count(cov1)
    );

    ovl_no_overflow_chk #(
        .WIDTH(4), .MIN(2), .MAX(9), .SEVERITY(3), .MSG("W4"), .COVER_EN(1'b1)
    ) dut4 (
        .clock(clk), .reset(rst_n), .enable(en4), .test_expr(te4),
        .fire(fire4), .err_count(err4), .cov_count(cov4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step4(input logic [3:0] v, input logic [2:0] f_exp,
                         input logic [15:0] e_exp, input string tag);
        te4 = v;
        tick();
        chk({tag, ".fire"}, 32'(fire4), 32'(f_exp));
        chk({tag, ".err"}, 32'(err4), 32'(e_exp));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        te1 = 1'b1;
        #1;
        chk("rst.fire1", 32'(fire1), 32'd0);
        chk("rst.err1", 32'(err1), 32'd0);
        chk("rst.cov1", 32'(cov1), 32'd0);
        chk("rst.fire4", 32'(fire4), 32'd0);
        repeat (5) tick();
        chk("rst_hold.fire1", 32'(fire1), 32'd0);
        chk("rst_hold.cov1", 32'(cov1), 32'd0);

        // 1-bit: MAX held for 10 evaluated edges only covers, never overflows.
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold1.fire0", 32'(fire1[0]), 32'd0);
        end
        chk("hold1.fire", 32'(fire1), 32'b100);
        chk("hold1.err", 32'(err1), 32'd0);
        chk("hold1.cov", 32'(cov1), 32'd10);

        // Reset acts immediately, without waiting for an edge.
        rst_n = 1'b0;
        #2;
        chk("async_rst.fire1", 32'(fire1), 32'd0);
        chk("async_rst.cov1", 32'(cov1), 32'd0);
        rst_n = 1'b1;

        te1 = 1'b0; tick();
        chk("w1_s0.fire", 32'(fire1), 32'b000);
        te1 = 1'b1; tick();
        chk("w1_s1.fire", 32'(fire1), 32'b100);
        te1 = 1'b0; tick();
        chk("w1_s2.fire", 32'(fire1), 32'b001);
        chk("w1_s2.err", 32'(err1), 32'd1);
        chk("w1_s2.cov", 32'(cov1), 32'd1);
        tick();
        chk("w1_s3.fire", 32'(fire1), 32'b000);
        chk("w1_s3.err", 32'(err1), 32'd1);

        // 4-bit instance, legal range (2,9).
        en4 = 1'b1;
        step4(4'd8,  3'b000, 16'd0, "w4_8");
        step4(4'd9,  3'b100, 16'd0, "w4_9a");
        step4(4'd10, 3'b001, 16'd1, "w4_10");
        step4(4'd9,  3'b100, 16'd1, "w4_9b");
        step4(4'd3,  3'b000, 16'd1, "w4_3");
        step4(4'd9,  3'b100, 16'd1, "w4_9c");
        step4(4'd2,  3'b001, 16'd2, "w4_2");
        step4(4'd9,  3'b100, 16'd2, "w4_9d");
        step4(4'd9,  3'b100, 16'd2, "w4_9e");
        step4(4'd15, 3'b001, 16'd3, "w4_15");
        step4(4'd9,  3'b100, 16'd3, "w4_9f");
        chk("w4.cov", 32'(cov4), 32'd6);

        // Disabled: no fire, counters frozen, history stays at 9.
        en4 = 1'b0;
        step4(4'd0, 3'b000, 16'd3, "w4_dis0");
        step4(4'd0, 3'b000, 16'd3, "w4_dis1");
        chk("w4_dis.cov", 32'(cov4), 32'd6);
        // Re-enabled with 0: the held 9 is the history, so 9 -> 0 is an overflow.
        en4 = 1'b1;
        step4(4'd0, 3'b001, 16'd4, "w4_reen");
        step4(4'd3, 3'b000, 16'd4, "w4_3b");

        // Unknown sample: x-check bit only where the simulator keeps X.
        te4 = 4'bxxxx;
        exp_x = $isunknown(te4);
        tick();
        chk("w4_x.fire0", 32'(fire4[0]), 32'd0);
        chk("w4_x.fire1", 32'(fire4[1]), 32'(exp_x));
        chk("w4_x.err", 32'(err4), 32'd4);
        step4(4'd9, 3'b100, 16'd4, "w4_9g");

        // Reset while prev==MAX: the 9 -> 0 across reset is not an overflow.
        rst_n = 1'b0;
        #2;
        chk("rst4.fire", 32'(fire4), 32'd0);
        chk("rst4.err", 32'(err4), 32'd0);
        chk("rst4.cov", 32'(cov4), 32'd0);
        rst_n = 1'b1;
        step4(4'd0, 3'b000, 16'd0, "w4_post0");
        step4(4'd9, 3'b100, 16'd0, "w4_post9");
        step4(4'd0, 3'b001, 16'd1, "w4_post_ovf");
        chk("w4_post.cov", 32'(cov4), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
